discr_trig: RTL and testbench
=============================

# discr_trig

Sample-stream discriminator sitting directly downstream of the 12-bit magnitude comparator in the mDOM trigger path. Applies the comparator's selectable condition (A>B / A<B / A=B, A = ADC sample, B = threshold) to each valid ADC sample. Requires a programmable number of consecutive qualifying samples, then emits a single-cycle trigger with the captured sample. Afterwards enforces a holdoff and re-arm before the next trigger; output feeds the waveform-capture / readout logic.

## Interface
- P_NSAMP_W, 4: width of the consecutive-sample qualifier.
- P_HOLD_W, 16: width of the holdoff counter (clk cycles).
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset; one clock domain only.
- adc_data  in  12  ADC sample, unsigned.
- adc_valid  in  1  sample strobe; adc_data is ignored when low.
- thresh  in  12  threshold (comparator B input); sampled every cycle.
- gt / lt / et  in  1 each  condition selects, passed to the comparator; any combination is legal.
- en  in  1  discriminator enable.
- min_samp  in  P_NSAMP_W  consecutive qualifying samples required; 0 is treated as 1.
- holdoff  in  P_HOLD_W  dead time after a trigger, in clk cycles.
- trig  out  1  one-cycle trigger pulse.
- trig_data  out  12  adc_data of the sample that completed qualification; held until the next trigger.
- armed  out  1  high in ARMED or QUAL.
- trig_cnt  out  32  trigger count, saturating; see Configuration.

## Operation
- hit = comparator output on (adc_data, thresh, gt, lt, et), qualified by adc_valid. With gt=lt=et=0, hit is never true.
- States:
  - IDLE:
    - en=1 → ARMED.
  - ARMED:
    - valid and hit → QUAL with qcnt=1.
    - If that first hit already meets the effective min_samp (1) → trig, go to HOLD.
  - QUAL:
    - valid and hit → qcnt+1.
    - When qcnt reaches the effective min_samp → trig, go to HOLD.
    - valid and !hit → ARMED, qcnt=0.
    - adc_valid low → hold state and qcnt; gaps do not break consecutiveness.
  - HOLD:
    - Loads hcnt=holdoff on entry and decrements each clk.
    - hcnt==0 → REARM.
    - holdoff=0 → spends exactly one cycle in HOLD.
  - REARM:
    - Waits for a valid sample with !hit, then → ARMED.
    - Prevents retriggering on one long pulse.
- en=0 in any state → IDLE next cycle; qcnt and hcnt are cleared; trig is not asserted that cycle even if qualification completes.
- trig_data is loaded only on the cycle trig is set.
- min_samp and holdoff are sampled at use: min_samp on each compare, holdoff at HOLD entry. A change during HOLD does not affect the running count.

## Timing
- Reset values: state IDLE, trig=0, trig_data=0, armed=0, trig_cnt=0, qcnt=0, hcnt=0.
- Trigger latency: trig is high in the cycle after the clk edge that samples the qualifying adc_valid/adc_data. Comparator path is combinational; the decision is registered.
- trig is high for exactly one cycle per trigger event.
- Minimum trigger-to-trigger spacing: 1 + holdoff + (cycles to first !hit) + min_samp valid samples.
- Reset asserted mid-QUAL or mid-HOLD: all outputs return to reset values asynchronously. After release the block re-enters via IDLE.

## Configuration
- DISCR_TRIG_CNT_EN defined:
  - trig_cnt increments on every trig and saturates at 0xFFFF_FFFF.
  - It is cleared only by rst_n; en=0 does not clear it.
- Not defined: trig_cnt is tied to 0 and no counter registers are synthesized.

## Structure
- Shared package `discr_trig_pkg`: the state enum (IDLE, ARMED, QUAL, HOLD, REARM), ADC width constant (12), and trig_cnt width (32).
- One sub-module: instantiate `cmp` for the hit decision. No local reimplementation of the compare.

## Test plan
- Rising edge: thresh=0x800, gt=1, min_samp=3, holdoff=10, samples 0x100, 0x900, 0x900, 0x900 → one trig cycle after the 3rd 0x900 sample; trig_data=0x900.
- Broken run: min_samp=3, samples 0x900, 0x900, 0x100, 0x900, 0x900, 0x100 → no trig; armed stays high.
- Long pulse: gt=1, min_samp=1, holdoff=0, 50 consecutive 0x900 samples → exactly one trig; the next trig fires only after a 0x100 sample followed by 0x900.
- adc_valid gaps: min_samp=2, valid 0x900, 5 idle cycles, valid 0x900 → trig.
- en drop and reset in HOLD:
  - en=0 during HOLD → IDLE; re-enable → ARMED.
  - rst_n pulse during QUAL → all outputs 0 immediately, including trig_cnt.
- Counter: with DISCR_TRIG_CNT_EN, 5 triggers → trig_cnt=5. Force the preload to 0xFFFF_FFFE, then 3 triggers → trig_cnt=0xFFFF_FFFF. Without the macro, trig_cnt=0 throughout.

Source files
------------

// File: rtl/discr_trig_pkg.sv
// Shared types and widths for the discr_trig sample discriminator.
package discr_trig_pkg;

    localparam int unsigned ADC_W = 12;
    localparam int unsigned CNT_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_QUAL,
        ST_HOLD,
        ST_REARM
    } state_e;

endpackage

// File: rtl/discr_trig_if.sv
// ADC sample stream between the converter front end and the discriminator.
interface discr_trig_if;
    import discr_trig_pkg::*;

    logic [ADC_W-1:0] adc_data;
    logic             adc_valid;

    modport master (output adc_data, output adc_valid);
    modport slave  (input  adc_data, input  adc_valid);
endinterface

// File: rtl/cmp.sv
// Magnitude comparator with selectable greater/less/equal conditions (combinational).
module cmp #(
    parameter int unsigned P_W = 12
) (
    input  logic [P_W-1:0] a_i,
    input  logic [P_W-1:0] b_i,
    input  logic           gt_i,
    input  logic           lt_i,
    input  logic           et_i,
    output logic           hit_c_o
);

    always_comb begin
        hit_c_o = (gt_i && (a_i > b_i)) ||
                  (lt_i && (a_i < b_i)) ||
                  (et_i && (a_i == b_i));
    end

endmodule

// File: rtl/discr_trig.sv
// Consecutive-sample trigger discriminator with holdoff and re-arm.
// Optional saturating trigger counter enabled by DISCR_TRIG_CNT_EN.
module discr_trig
    import discr_trig_pkg::*;
#(
    parameter int unsigned P_NSAMP_W = 4,
    parameter int unsigned P_HOLD_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    discr_trig_if.slave          adc_if,
    input  logic [ADC_W-1:0]     thresh_i,
    input  logic                 gt_i,
    input  logic                 lt_i,
    input  logic                 et_i,
    input  logic                 en_i,
    input  logic [P_NSAMP_W-1:0] min_samp_i,
    input  logic [P_HOLD_W-1:0]  holdoff_i,
    output logic                 trig_o,
    output logic [ADC_W-1:0]     trig_data_o,
    output logic                 armed_o,
    output logic [CNT_W-1:0]     trig_cnt_o
);

    localparam int unsigned QW = P_NSAMP_W + 1;

    state_e               state_q, state_d;
    logic [P_NSAMP_W-1:0] qcnt_q, qcnt_d;
    logic [P_HOLD_W-1:0]  hcnt_q, hcnt_d;
    logic                 trig_q, trig_d;
    logic [ADC_W-1:0]     trig_data_q, trig_data_d;
    logic                 armed_q, armed_d;

    logic                 hit_c;
    logic                 fire_c;
    logic [P_NSAMP_W-1:0] eff_min_c;
    logic [QW-1:0]        qnext_c;

    cmp #(.P_W(ADC_W)) u_cmp (
        .a_i     (adc_if.adc_data),
        .b_i     (thresh_i),
        .gt_i    (gt_i),
        .lt_i    (lt_i),
        .et_i    (et_i),
        .hit_c_o (hit_c)
    );

    // A programmed minimum of zero behaves as one.
    assign eff_min_c = (min_samp_i == '0) ? P_NSAMP_W'(1) : min_samp_i;
    assign qnext_c   = {1'b0, qcnt_q} + QW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            qcnt_q      <= '0;
            hcnt_q      <= '0;
            trig_q      <= 1'b0;
            trig_data_q <= '0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            qcnt_q      <= qcnt_d;
            hcnt_q      <= hcnt_d;
            trig_q      <= trig_d;
            trig_data_q <= trig_data_d;
            armed_q     <= armed_d;
        end
    end

    // ARMED always holds qcnt=0, so it shares the QUAL counting path.
    always_comb begin
        state_d = state_q;
        qcnt_d  = qcnt_q;
        hcnt_d  = hcnt_q;
        fire_c  = 1'b0;
        if (!en_i) begin
            state_d = ST_IDLE;
            qcnt_d  = '0;
            hcnt_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_ARMED;
                ST_ARMED, ST_QUAL: begin
                    if (adc_if.adc_valid) begin
                        if (hit_c) begin
                            if (qnext_c >= {1'b0, eff_min_c}) begin
                                fire_c  = 1'b1;
                                state_d = ST_HOLD;
                                qcnt_d  = '0;
                                hcnt_d  = holdoff_i;
                            end else begin
                                state_d = ST_QUAL;
                                qcnt_d  = qnext_c[P_NSAMP_W-1:0];
                            end
                        end else begin
                            state_d = ST_ARMED;
                            qcnt_d  = '0;
                        end
                    end
                end
                ST_HOLD: begin
                    if (hcnt_q == '0) state_d = ST_REARM;
                    else              hcnt_d  = hcnt_q - P_HOLD_W'(1);
                end
                ST_REARM: begin
                    if (adc_if.adc_valid && !hit_c) state_d = ST_ARMED;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        trig_d      = fire_c;
        trig_data_d = fire_c ? adc_if.adc_data : trig_data_q;
        armed_d     = (state_d == ST_ARMED) || (state_d == ST_QUAL);
    end

    assign trig_o      = trig_q;
    assign trig_data_o = trig_data_q;
    assign armed_o     = armed_q;

`ifdef DISCR_TRIG_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (trig_d && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    end

    // Cleared only by reset; disabling the discriminator keeps the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign trig_cnt_o = cnt_q;
`else
    assign trig_cnt_o = '0;
`endif

endmodule

// File: tb/tb_discr_trig.sv
// Self-checking bench for discr_trig: directed scenarios plus randomized traffic vs a behavioural model.
module tb_discr_trig;

    logic        clk;
    logic        rst_n;
    logic [11:0] thresh;
    logic        gt, lt, et, en;
    logic [3:0]  min_samp;
    logic [15:0] holdoff;
    logic        trig;
    logic [11:0] trig_data;
    logic        armed;
    logic [31:0] trig_cnt;

    int n_tests;
    int n_fail;

    discr_trig_if ifc ();

    discr_trig #(.P_NSAMP_W(4), .P_HOLD_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .adc_if      (ifc),
        .thresh_i    (thresh),
        .gt_i        (gt),
        .lt_i        (lt),
        .et_i        (et),
        .en_i        (en),
        .min_samp_i  (min_samp),
        .holdoff_i   (holdoff),
        .trig_o      (trig),
        .trig_data_o (trig_data),
        .armed_o     (armed),
        .trig_cnt_o  (trig_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: run length of hits, remaining dead cycles, pending re-arm.
    bit          m_live;
    bit          m_need_low;
    int          m_dead;
    int          m_run;
    bit          m_trig;
    logic [11:0] m_tdata;
    logic [31:0] m_cnt;

    function automatic bit cond_hit(input logic [11:0] a, input logic [11:0] b,
                                    input logic g, input logic l, input logic e);
        return (g && a > b) || (l && a < b) || (e && a == b);
    endfunction

    function automatic bit m_armed();
        return m_live && (m_dead == 0) && !m_need_low;
    endfunction

    task automatic model_reset();
        m_live = 0; m_need_low = 0; m_dead = 0; m_run = 0;
        m_trig = 0; m_tdata = '0; m_cnt = '0;
    endtask

    task automatic model_step();
        bit h;
        int eff;
        h   = cond_hit(ifc.adc_data, thresh, gt, lt, et);
        eff = (min_samp == 0) ? 1 : int'(min_samp);
        m_trig = 0;
        if (!en) begin
            m_live = 0; m_run = 0; m_dead = 0; m_need_low = 0;
        end else if (!m_live) begin
            m_live = 1;
        end else if (m_dead > 0) begin
            m_dead--;
        end else if (m_need_low) begin
            if (ifc.adc_valid && !h) m_need_low = 0;
        end else if (ifc.adc_valid) begin
            if (h) begin
                m_run++;
                if (m_run >= eff) begin
                    m_trig     = 1;
                    m_tdata    = ifc.adc_data;
                    m_run      = 0;
                    m_dead     = int'(holdoff) + 1;
                    m_need_low = 1;
`ifdef DISCR_TRIG_CNT_EN
                    if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
`endif
                end
            end else begin
                m_run = 0;
            end
        end
    endtask

    // Drive one sample at the falling edge, advance the model at the rising edge, settle.
    task automatic cycle(input logic v, input logic [11:0] d);
        @(negedge clk);
        ifc.adc_valid = v;
        ifc.adc_data  = d;
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    task automatic rearm();
        en = 1'b0;
        cycle(1'b0, 12'h000);
        en = 1'b1;
        cycle(1'b0, 12'h000);
    endtask

    task automatic test_reset();
        #3;
        n_tests++; if (trig !== 1'b0)       begin n_fail++; $display("FAIL reset_trig: got %b expected 0", trig); end
        n_tests++; if (trig_data !== 12'h0) begin n_fail++; $display("FAIL reset_trig_data: got %h expected 000", trig_data); end
        n_tests++; if (armed !== 1'b0)      begin n_fail++; $display("FAIL reset_armed: got %b expected 0", armed); end
        n_tests++; if (trig_cnt !== 32'h0)  begin n_fail++; $display("FAIL reset_trig_cnt: got %h expected 0", trig_cnt); end
        cycle(1'b0, 12'h000);
        rst_n = 1'b1;
    endtask

    task automatic test_rising_edge();
        thresh = 12'h800; gt = 1; lt = 0; et = 0; min_samp = 4'd3; holdoff = 16'd10;
        rearm();
        n_tests++; if (armed !== 1'b1) begin n_fail++; $display("FAIL rise_armed: got %b expected 1", armed); end
        cycle(1'b1, 12'h100);
        cycle(1'b1, 12'h900);
        cycle(1'b1, 12'h900);
        n_tests++; if (trig !== 1'b0) begin n_fail++; $display("FAIL rise_early: got %b expected 0", trig); end
        cycle(1'b1, 12'h900);
        n_tests++; if (trig !== 1'b1)       begin n_fail++; $display("FAIL rise_trig: got %b expected 1", trig); end
        n_tests++; if (trig_data !== 12'h900) begin n_fail++; $display("FAIL rise_data: got %h expected 900", trig_data); end
        n_tests++; if (armed !== 1'b0)      begin n_fail++; $display("FAIL rise_hold_armed: got %b expected 0", armed); end
        cycle(1'b1, 12'h100);
        n_tests++; if (trig !== 1'b0) begin n_fail++; $display("FAIL rise_one_cycle: got %b expected 0", trig); end
        n_tests++; if (trig_cnt !== m_cnt) begin n_fail++; $display("FAIL rise_cnt: got %h expected %h", trig_cnt, m_cnt); end
    endtask

    task automatic test_broken_run();
        logic [11:0] seq [6];
        seq = '{12'h900, 12'h900, 12'h100, 12'h900, 12'h900, 12'h100};
        min_samp = 4'd3; holdoff = 16'd10;
        rearm();
        foreach (seq[i]) begin
            cycle(1'b1, seq[i]);
            n_tests++;
            if (trig !== 1'b0 || armed !== 1'b1) begin
                n_fail++; $display("FAIL broken_run[%0d]: got trig=%b armed=%b expected trig=0 armed=1", i, trig, armed);
            end
        end
    endtask

    task automatic test_long_pulse();
        int trigs;
        min_samp = 4'd1; holdoff = 16'd0;
        rearm();
        trigs = 0;
        repeat (50) begin
            cycle(1'b1, 12'h900);
            if (trig === 1'b1) trigs++;
        end
        n_tests++; if (trigs !== 1) begin n_fail++; $display("FAIL long_pulse_count: got %0d expected 1", trigs); end
        n_tests++; if (armed !== 1'b0) begin n_fail++; $display("FAIL long_pulse_rearm: got %b expected 0", armed); end
        cycle(1'b1, 12'h100);
        n_tests++; if (armed !== 1'b1) begin n_fail++; $display("FAIL long_pulse_rearmed: got %b expected 1", armed); end
        cycle(1'b1, 12'h900);
        n_tests++; if (trig !== 1'b1) begin n_fail++; $display("FAIL long_pulse_retrig: got %b expected 1", trig); end
    endtask

    task automatic test_gaps();
        min_samp = 4'd2; holdoff = 16'd10;
        rearm();
        cycle(1'b1, 12'h900);
        repeat (5) begin
            cycle(1'b0, 12'h000);
            n_tests++;
            if (trig !== 1'b0 || armed !== 1'b1) begin
                n_fail++; $display("FAIL gaps_idle: got trig=%b armed=%b expected trig=0 armed=1", trig, armed);
            end
        end
        cycle(1'b1, 12'h955);
        n_tests++; if (trig !== 1'b1)        begin n_fail++; $display("FAIL gaps_trig: got %b expected 1", trig); end
        n_tests++; if (trig_data !== 12'h955) begin n_fail++; $display("FAIL gaps_data: got %h expected 955", trig_data); end
    endtask

    task automatic test_en_drop();
        min_samp = 4'd1; holdoff = 16'd20;
        rearm();
        cycle(1'b1, 12'hA00);
        n_tests++; if (trig !== 1'b1) begin n_fail++; $display("FAIL en_trig: got %b expected 1", trig); end
        repeat (3) cycle(1'b0, 12'h000);
        en = 1'b0;
        cycle(1'b1, 12'hA00);
        n_tests++; if (armed !== 1'b0 || trig !== 1'b0) begin n_fail++; $display("FAIL en_idle: got armed=%b trig=%b expected 0 0", armed, trig); end
        en = 1'b1;
        cycle(1'b1, 12'hA00);
        n_tests++; if (armed !== 1'b1 || trig !== 1'b0) begin n_fail++; $display("FAIL en_rearmed: got armed=%b trig=%b expected 1 0", armed, trig); end
        cycle(1'b1, 12'hA00);
        n_tests++; if (trig !== 1'b1) begin n_fail++; $display("FAIL en_retrig: got %b expected 1", trig); end
    endtask

    task automatic test_reset_mid_qual();
        min_samp = 4'd5; holdoff = 16'd10;
        rearm();
        cycle(1'b1, 12'h900);
        cycle(1'b1, 12'h900);
        n_tests++; if (armed !== 1'b1) begin n_fail++; $display("FAIL rstq_armed: got %b expected 1", armed); end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if (trig !== 1'b0 || trig_data !== 12'h0 || armed !== 1'b0 || trig_cnt !== 32'h0) begin
            n_fail++; $display("FAIL rstq_clear: got trig=%b data=%h armed=%b cnt=%h expected all 0", trig, trig_data, armed, trig_cnt);
        end
        cycle(1'b0, 12'h000);
        rst_n = 1'b1;
        cycle(1'b0, 12'h000);
        n_tests++; if (armed !== 1'b1) begin n_fail++; $display("FAIL rstq_reentry: got %b expected 1", armed); end
    endtask

    task automatic test_counter();
        min_samp = 4'd1; holdoff = 16'd0;
        rearm();
        repeat (5) begin
            cycle(1'b1, 12'h900);
            cycle(1'b1, 12'h100);
            cycle(1'b1, 12'h100);
        end
`ifdef DISCR_TRIG_CNT_EN
        n_tests++; if (trig_cnt !== 32'd5) begin n_fail++; $display("FAIL cnt_five: got %h expected 5", trig_cnt); end
        @(negedge clk);
        ifc.adc_valid = 1'b0;
        force dut.cnt_q = 32'hFFFF_FFFE;
        @(posedge clk);
        model_step();
        #1;
        release dut.cnt_q;
        m_cnt = 32'hFFFF_FFFE;
        repeat (3) begin
            cycle(1'b1, 12'h900);
            cycle(1'b1, 12'h100);
            cycle(1'b1, 12'h100);
        end
        n_tests++; if (trig_cnt !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL cnt_sat: got %h expected ffffffff", trig_cnt); end
`else
        n_tests++; if (trig_cnt !== 32'd0) begin n_fail++; $display("FAIL cnt_tied: got %h expected 0", trig_cnt); end
`endif
    endtask

    task automatic test_random();
        logic        level_hi;
        logic [11:0] d;
        level_hi = 1'b0;
        thresh = 12'h800;
        for (int c = 0; c < 3000; c++) begin
            if ((c % 64) == 0) begin
                min_samp = 4'($urandom_range(0, 4));
                holdoff  = 16'($urandom_range(0, 6));
                {gt, lt, et} = 3'($urandom_range(0, 7));
                thresh = 12'($urandom_range(12'h7F0, 12'h810));
            end
            en = ($urandom_range(0, 99) < 97);
            if ($urandom_range(0, 99) < 20) level_hi = ~level_hi;
            case ($urandom_range(0, 3))
                0:       d = thresh;
                1:       d = 12'($urandom_range(0, 12'hFFF));
                default: d = level_hi ? 12'hC00 : 12'h200;
            endcase
            cycle(($urandom_range(0, 3) != 0), d);
            n_tests++;
            if (trig !== m_trig || trig_data !== m_tdata || armed !== m_armed() || trig_cnt !== m_cnt) begin
                n_fail++;
                $display("FAIL random[%0d]: got trig=%b data=%h armed=%b cnt=%h expected trig=%b data=%h armed=%b cnt=%h",
                         c, trig, trig_data, armed, trig_cnt, m_trig, m_tdata, m_armed(), m_cnt);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0; n_fail = 0;
        rst_n = 1'b0; en = 1'b0; gt = 1'b0; lt = 1'b0; et = 1'b0;
        thresh = 12'h000; min_samp = 4'd0; holdoff = 16'd0;
        ifc.adc_valid = 1'b0; ifc.adc_data = 12'h000;
        model_reset();
        test_reset();
        test_rising_edge();
        test_broken_run();
        test_long_pulse();
        test_gaps();
        test_en_drop();
        test_reset_mid_qual();
        test_counter();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
